// File: rtl/reciprocal_ctrl_if.sv
// Signal bundle between the reciprocal controller and its surroundings:
// operand handshake, CORDIC datapath control and result handshake.
interface reciprocal_ctrl_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] dp_x;
    logic         dp_loadX;
    logic         dp_start;
    logic         dp_done;
    logic [W-1:0] dp_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [1:0]   out_err;
    logic         busy;

    // Controller view
    modport slave (
        input  in_valid, in_x, dp_done, dp_out, out_ready,
        output in_ready, dp_x, dp_loadX, dp_start, out_valid, out_result, out_err, busy
    );

    // Producer / datapath / consumer view
    modport master (
        output in_valid, in_x, dp_done, dp_out, out_ready,
        input  in_ready, dp_x, dp_loadX, dp_start, out_valid, out_result, out_err, busy
    );
endinterface

// File: rtl/reciprocal_ctrl.sv
// Sequencing controller for the CORDIC reciprocal datapath: accepts an
// operand, screens |x| < 0.5, pulses the core, waits for done with a
// timeout guard and holds the registered result until it is consumed.
module reciprocal_ctrl #(
    parameter int FLOAT_SIZE     = 24,
    parameter int INT_SIZE       = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    reciprocal_ctrl_if.slave  bus
);
    localparam int W  = INT_SIZE + FLOAT_SIZE;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic signed [W-1:0] C_HALF  = W'(1) << (FLOAT_SIZE - 1);
    localparam logic signed [W-1:0] C_NHALF = -C_HALF;
    localparam logic [W-1:0]        C_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]        C_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0]       C_TLAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_result;
    logic [1:0]      r_err;

    logic            w_accept;
    logic            w_in_range;
    logic            w_timeout;

    // Linear vectoring only converges for |x| >= 0.5; the most-negative
    // code satisfies x <= -HALF and is therefore accepted.
    assign w_in_range = ($signed(bus.in_x) >= C_HALF) || ($signed(bus.in_x) <= C_NHALF);
    assign w_accept   = bus.in_valid && (r_state == S_IDLE);
    assign w_timeout  = (r_cnt == C_TLAST);

    assign bus.dp_x       = bus.in_x;
    assign bus.out_result = r_result;
    assign bus.out_err    = r_err;

    // Next-state decode and state-derived handshake/control outputs
    always_comb begin
        w_next       = r_state;
        bus.in_ready = 1'b0;
        bus.dp_loadX = 1'b0;
        bus.dp_start = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                bus.dp_loadX = w_accept;
                if (w_accept) w_next = w_in_range ? S_START : S_OUT;
            end
            S_START: begin
                bus.dp_start = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                if (bus.dp_done || w_timeout) w_next = S_OUT;
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                // Handoff cycle returns to IDLE; in_ready rises only after it
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Timeout counter and result/error capture; done beats a coincident timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= ERR_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !w_in_range) begin
                        r_result <= bus.in_x[W-1] ? C_MIN : C_MAX;
                        r_err    <= ERR_RANGE;
                    end
                end
                S_START: r_cnt <= '0;
                S_WAIT: begin
                    if (bus.dp_done) begin
                        r_result <= bus.dp_out;
                        r_err    <= ERR_OK;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= ERR_TMO;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
